// File: rtl/seg7_scan_decoder.sv
// Recovers a 4-digit hex value from a multiplexed, active-low 7-segment scan bus.
// Stable one-hot digit samples are decoded into slots; a full set of four produces one frame.
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic        valid,
  output logic        err,
  output logic [3:0]  digit_err,
  output logic        timeout
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_LAST   = IW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t          state, state_n;
  logic [10:0]     s_meta, s_sync, s_prev;
  logic [CW-1:0]   stab_cnt;
  logic [IW-1:0]   idle_cnt, idle_n;
  logic [3:0]      seen, seen_n, pend, pend_n;
  logic [15:0]     slots, slots_n;
  logic [3:0]      an_s;
  logic [6:0]      seg_s;
  logic [1:0]      slot_idx;
  logic            slot_ok;
  logic            accept;
  logic [4:0]      dec;
  logic [15:0]     wr_slots;
  logic [3:0]      wr_pend, wr_seen;
  logic            fire, tmo;

  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    case (p)
      7'h40: return 5'h00;
      7'h79: return 5'h01;
      7'h24: return 5'h02;
      7'h30: return 5'h03;
      7'h19: return 5'h04;
      7'h12: return 5'h05;
      7'h02: return 5'h06;
      7'h58: return 5'h07;
      7'h00: return 5'h08;
      7'h10: return 5'h09;
      7'h08: return 5'h0A;
      7'h03: return 5'h0B;
      7'h46: return 5'h0C;
      7'h21: return 5'h0D;
      7'h06: return 5'h0E;
      7'h0E: return 5'h0F;
      default: return 5'h10;  // error flag set, nibble 0
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta   <= '1;
      s_sync   <= '1;
      s_prev   <= '1;
      stab_cnt <= '0;
    end else begin
      s_meta <= {an, seg};
      s_sync <= s_meta;
      s_prev <= s_sync;
      if (s_sync != s_prev)
        stab_cnt <= '0;
      else if (stab_cnt != STABLE_MAX)
        stab_cnt <= stab_cnt + 1'b1;
    end
  end

  always_comb begin
    an_s     = s_sync[10:7];
    seg_s    = s_sync[6:0];
    slot_ok  = 1'b1;
    slot_idx = 2'd0;
    case (an_s)
      4'b1110: slot_idx = 2'd0;
      4'b1101: slot_idx = 2'd1;
      4'b1011: slot_idx = 2'd2;
      4'b0111: slot_idx = 2'd3;
      default: slot_ok  = 1'b0;
    endcase
    // Counter saturates, so this transition occurs once per stable period.
    accept = (s_sync == s_prev) && (stab_cnt == STABLE_LAST) && slot_ok;
    dec    = seg_decode(seg_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    seen_n   = seen;
    pend_n   = pend;
    slots_n  = slots;
    idle_n   = idle_cnt;
    fire     = 1'b0;
    tmo      = 1'b0;
    wr_slots = slots;
    wr_slots[{slot_idx, 2'b00} +: 4] = dec[3:0];
    wr_pend  = pend;
    wr_pend[slot_idx] = dec[4];
    wr_seen  = seen;
    wr_seen[slot_idx] = 1'b1;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = COLLECT;
          seen_n  = wr_seen;
          pend_n  = wr_pend;
          slots_n = wr_slots;
          idle_n  = '0;
        end
      end
      COLLECT: begin
        // Acceptance is tested first so it pre-empts a coincident timeout.
        if (accept) begin
          slots_n = wr_slots;
          idle_n  = '0;
          if (&wr_seen) begin
            fire    = 1'b1;
            seen_n  = '0;
            pend_n  = '0;
            state_n = IDLE;
          end else begin
            seen_n = wr_seen;
            pend_n = wr_pend;
          end
        end else if (idle_cnt == IDLE_LAST) begin
          tmo     = 1'b1;
          seen_n  = '0;
          pend_n  = '0;
          idle_n  = '0;
          state_n = IDLE;
        end else begin
          idle_n = idle_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen      <= '0;
      pend      <= '0;
      slots     <= '0;
      idle_cnt  <= '0;
      value     <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
      digit_err <= '0;
      timeout   <= 1'b0;
    end else begin
      seen     <= seen_n;
      pend     <= pend_n;
      slots    <= slots_n;
      idle_cnt <= idle_n;
      valid    <= fire;
      timeout  <= tmo;
      if (fire) begin
        value     <= wr_slots;
        digit_err <= wr_pend;
        err       <= |wr_pend;
      end
    end
  end

endmodule
